// File: rtl/fft16_scheduler_if.sv
// rtl/fft16_scheduler_if.sv - sample, bin and butterfly bus of the 16-point FFT scheduler
interface fft16_scheduler_if #(
   parameter int WORD_SIZE = 16
);
   logic                 i_start;
   logic                 i_in_valid;
   logic                 o_in_ready;
   logic [WORD_SIZE-1:0] i_in_re;
   logic [WORD_SIZE-1:0] i_in_im;
   logic                 o_out_valid;
   logic                 i_out_ready;
   logic [WORD_SIZE-1:0] o_out_re;
   logic [WORD_SIZE-1:0] o_out_im;
   logic [3:0]           o_out_index;
   logic                 o_bf_start;
   logic [WORD_SIZE-1:0] o_bf_in0_re;
   logic [WORD_SIZE-1:0] o_bf_in0_im;
   logic [WORD_SIZE-1:0] o_bf_in1_re;
   logic [WORD_SIZE-1:0] o_bf_in1_im;
   logic [WORD_SIZE-1:0] o_bf_twiddle_re;
   logic [WORD_SIZE-1:0] o_bf_twiddle_im;
   logic                 i_bf_done;
   logic [WORD_SIZE-1:0] i_bf_out0_re;
   logic [WORD_SIZE-1:0] i_bf_out0_im;
   logic [WORD_SIZE-1:0] i_bf_out1_re;
   logic [WORD_SIZE-1:0] i_bf_out1_im;
   logic                 o_busy;
   logic [1:0]           o_stage;
   logic                 o_frame_done;

   modport slave (
      input  i_start, i_in_valid, i_in_re, i_in_im, i_out_ready,
      input  i_bf_done, i_bf_out0_re, i_bf_out0_im, i_bf_out1_re, i_bf_out1_im,
      output o_in_ready, o_out_valid, o_out_re, o_out_im, o_out_index,
      output o_bf_start, o_bf_in0_re, o_bf_in0_im, o_bf_in1_re, o_bf_in1_im,
      output o_bf_twiddle_re, o_bf_twiddle_im, o_busy, o_stage, o_frame_done
   );

   modport master (
      output i_start, i_in_valid, i_in_re, i_in_im, i_out_ready,
      output i_bf_done, i_bf_out0_re, i_bf_out0_im, i_bf_out1_re, i_bf_out1_im,
      input  o_in_ready, o_out_valid, o_out_re, o_out_im, o_out_index,
      input  o_bf_start, o_bf_in0_re, o_bf_in0_im, o_bf_in1_re, o_bf_in1_im,
      input  o_bf_twiddle_re, o_bf_twiddle_im, o_busy, o_stage, o_frame_done
   );
endinterface

// File: rtl/fft16_scheduler.sv
// rtl/fft16_scheduler.sv - in-place radix-2 DIT sequencer driving an external butterfly
module fft16_scheduler #(
   parameter int WORD_SIZE = 16,
   parameter int FRACTION  = 8
) (
   input logic              i_clk,
   input logic              i_rst,
   fft16_scheduler_if.slave bus
);
   localparam int W = WORD_SIZE;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_ISSUE,
      S_WAIT,
      S_WRITE,
      S_UNLOAD
   } state_t;

   state_t       r_state;
   logic [1:0]   r_s;
   logic [2:0]   r_b;
   logic [3:0]   r_n;
   logic [3:0]   r_i;
   logic [W-1:0] r_mem_re [16];
   logic [W-1:0] r_mem_im [16];
   logic [W-1:0] r_res0_re, r_res0_im, r_res1_re, r_res1_im;
   logic         r_in_ready, r_out_valid, r_bf_start, r_busy, r_frame_done;
   logic [W-1:0] r_out_re, r_out_im;
   logic [W-1:0] r_in0_re, r_in0_im, r_in1_re, r_in1_im;
   logic [W-1:0] r_tw_re, r_tw_im;

   logic [10:0]  w_cur_addr;
   logic [10:0]  w_nxt_addr;
   logic [1:0]   w_nxt_s;
   logic [2:0]   w_nxt_b;
   logic [3:0]   w_cur_idx0, w_cur_idx1, w_nxt_idx0, w_nxt_idx1;

   function automatic logic [3:0] bitrev4(input logic [3:0] v);
      return {v[0], v[1], v[2], v[3]};
   endfunction

   // Packs {idx0, idx1, k}; idx0 always has bit s clear, so idx1 = idx0 + 2^s is an OR.
   function automatic logic [10:0] bf_addr(input logic [1:0] s, input logic [2:0] b);
      logic [3:0] idx0;
      logic [2:0] k;
      case (s)
         2'd0:    begin idx0 = {b, 1'b0};                k = 3'd0;            end
         2'd1:    begin idx0 = {b[2:1], 1'b0, b[0]};     k = {b[0], 2'b00};   end
         2'd2:    begin idx0 = {b[2], 1'b0, b[1:0]};     k = {b[1:0], 1'b0};  end
         default: begin idx0 = {1'b0, b};                k = b;               end
      endcase
      return {idx0, idx0 | (4'd1 << s), k};
   endfunction

   // Table holds Q8.8 values; rescaled so that FRACTION=8 is an exact identity.
   function automatic logic [2*W-1:0] twiddle(input logic [2:0] k);
      int re_q8;
      int im_q8;
      case (k)
         3'd0:    begin re_q8 = 256;  im_q8 = 0;    end
         3'd1:    begin re_q8 = 237;  im_q8 = -98;  end
         3'd2:    begin re_q8 = 181;  im_q8 = -181; end
         3'd3:    begin re_q8 = 98;   im_q8 = -237; end
         3'd4:    begin re_q8 = 0;    im_q8 = -256; end
         3'd5:    begin re_q8 = -98;  im_q8 = -237; end
         3'd6:    begin re_q8 = -181; im_q8 = -181; end
         default: begin re_q8 = -237; im_q8 = -98;  end
      endcase
      return {W'((re_q8 * (1 << FRACTION)) / 256), W'((im_q8 * (1 << FRACTION)) / 256)};
   endfunction

   always_comb begin
      w_nxt_b    = r_b + 3'd1;
      w_nxt_s    = (r_b == 3'd7) ? r_s + 2'd1 : r_s;
      w_cur_addr = bf_addr(r_s, r_b);
      w_nxt_addr = bf_addr(w_nxt_s, w_nxt_b);
      w_cur_idx0 = w_cur_addr[10:7];
      w_cur_idx1 = w_cur_addr[6:3];
      w_nxt_idx0 = w_nxt_addr[10:7];
      w_nxt_idx1 = w_nxt_addr[6:3];
   end

   // Operands for the next butterfly are read on the same edge that writes the
   // previous result; the pairs never overlap, so no forwarding is needed.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_state      <= S_IDLE;
         r_s          <= 2'd0;
         r_b          <= 3'd0;
         r_n          <= 4'd0;
         r_i          <= 4'd0;
         r_in_ready   <= 1'b0;
         r_out_valid  <= 1'b0;
         r_bf_start   <= 1'b0;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
         r_out_re     <= '0;
         r_out_im     <= '0;
         r_in0_re     <= '0;
         r_in0_im     <= '0;
         r_in1_re     <= '0;
         r_in1_im     <= '0;
         r_tw_re      <= '0;
         r_tw_im      <= '0;
         r_res0_re    <= '0;
         r_res0_im    <= '0;
         r_res1_re    <= '0;
         r_res1_im    <= '0;
      end else begin
         r_frame_done <= 1'b0;
         r_bf_start   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.i_start) begin
                  r_state    <= S_LOAD;
                  r_n        <= 4'd0;
                  r_s        <= 2'd0;
                  r_b        <= 3'd0;
                  r_i        <= 4'd0;
                  r_in_ready <= 1'b1;
                  r_busy     <= 1'b1;
               end
            end
            S_LOAD: begin
               if (bus.i_in_valid) begin
                  r_mem_re[bitrev4(r_n)] <= bus.i_in_re;
                  r_mem_im[bitrev4(r_n)] <= bus.i_in_im;
                  r_n                    <= r_n + 4'd1;
                  if (r_n == 4'd15) begin
                     r_in_ready           <= 1'b0;
                     r_state              <= S_ISSUE;
                     r_bf_start           <= 1'b1;
                     r_in0_re             <= r_mem_re[w_cur_idx0];
                     r_in0_im             <= r_mem_im[w_cur_idx0];
                     r_in1_re             <= r_mem_re[w_cur_idx1];
                     r_in1_im             <= r_mem_im[w_cur_idx1];
                     {r_tw_re, r_tw_im}   <= twiddle(w_cur_addr[2:0]);
                  end
               end
            end
            S_ISSUE: begin
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (bus.i_bf_done) begin
                  r_res0_re <= bus.i_bf_out0_re;
                  r_res0_im <= bus.i_bf_out0_im;
                  r_res1_re <= bus.i_bf_out1_re;
                  r_res1_im <= bus.i_bf_out1_im;
                  r_state   <= S_WRITE;
               end
            end
            S_WRITE: begin
               r_mem_re[w_cur_idx0] <= r_res0_re;
               r_mem_im[w_cur_idx0] <= r_res0_im;
               r_mem_re[w_cur_idx1] <= r_res1_re;
               r_mem_im[w_cur_idx1] <= r_res1_im;
               r_b                  <= w_nxt_b;
               r_s                  <= w_nxt_s;
               if (r_s == 2'd3 && r_b == 3'd7) begin
                  r_state     <= S_UNLOAD;
                  r_out_valid <= 1'b1;
                  r_out_re    <= r_mem_re[0];
                  r_out_im    <= r_mem_im[0];
                  r_i         <= 4'd0;
               end else begin
                  r_state            <= S_ISSUE;
                  r_bf_start         <= 1'b1;
                  r_in0_re           <= r_mem_re[w_nxt_idx0];
                  r_in0_im           <= r_mem_im[w_nxt_idx0];
                  r_in1_re           <= r_mem_re[w_nxt_idx1];
                  r_in1_im           <= r_mem_im[w_nxt_idx1];
                  {r_tw_re, r_tw_im} <= twiddle(w_nxt_addr[2:0]);
               end
            end
            S_UNLOAD: begin
               if (bus.i_out_ready) begin
                  if (r_i == 4'd15) begin
                     r_out_valid  <= 1'b0;
                     r_frame_done <= 1'b1;
                     r_busy       <= 1'b0;
                     r_i          <= 4'd0;
                     r_state      <= S_IDLE;
                  end else begin
                     r_i      <= r_i + 4'd1;
                     r_out_re <= r_mem_re[r_i + 4'd1];
                     r_out_im <= r_mem_im[r_i + 4'd1];
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.o_in_ready      = r_in_ready;
   assign bus.o_out_valid     = r_out_valid;
   assign bus.o_out_re        = r_out_re;
   assign bus.o_out_im        = r_out_im;
   assign bus.o_out_index     = r_i;
   assign bus.o_bf_start      = r_bf_start;
   assign bus.o_bf_in0_re     = r_in0_re;
   assign bus.o_bf_in0_im     = r_in0_im;
   assign bus.o_bf_in1_re     = r_in1_re;
   assign bus.o_bf_in1_im     = r_in1_im;
   assign bus.o_bf_twiddle_re = r_tw_re;
   assign bus.o_bf_twiddle_im = r_tw_im;
   assign bus.o_busy          = r_busy;
   assign bus.o_stage         = r_s;
   assign bus.o_frame_done    = r_frame_done;
endmodule

// File: tb/tb_fft16_scheduler.sv
// tb/tb_fft16_scheduler.sv - scoreboard bench for the 16-point FFT scheduler
`timescale 1ns/1ps
module tb_fft16_scheduler;
   localparam int W = 16;

   typedef struct packed {
      logic signed [W-1:0] re;
      logic signed [W-1:0] im;
      logic [3:0]          idx;
   } bin_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   fft16_scheduler_if #(.WORD_SIZE(W)) bus ();
   fft16_scheduler #(.WORD_SIZE(W), .FRACTION(8)) dut (.i_clk(clk), .i_rst(rst_n), .bus(bus));

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int bf_latency = 3;
   bit bf_mode = 1'b0;
   bit chk_issue = 1'b0;
   bit spurious_done = 1'b0;
   int issue_cnt = 0;
   int last_start_cyc = 0;
   int first_valid_cyc = -1;
   int tol = 0;
   bin_t exp_q[$];
   logic signed [W-1:0] x_re [16];
   logic signed [W-1:0] x_im [16];
   int tw_re_t [8] = '{256, 237, 181, 98, 0, -98, -181, -237};
   int tw_im_t [8] = '{0, -98, -181, -237, -256, -237, -181, -98};

   function automatic int brev(input int v);
      return ((v & 1) << 3) | ((v & 2) << 1) | ((v & 4) >> 1) | ((v & 8) >> 3);
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // External butterfly: pass-through or Q8.8 reference, done N cycles after start.
   initial begin : bf_model
      int cnt, s, b, p, g, i0, i1, k, pr, pi;
      bit pend;
      logic signed [W-1:0] a_re, a_im, b_re, b_im, w_re, w_im;
      logic [79:0] obs, expv;
      pend = 1'b0;
      cnt = 0;
      bus.i_bf_done = 1'b0;
      bus.i_bf_out0_re = '0; bus.i_bf_out0_im = '0;
      bus.i_bf_out1_re = '0; bus.i_bf_out1_im = '0;
      forever begin
         @(posedge clk); #1;
         bus.i_bf_done = spurious_done;
         if (pend) begin
            cnt--;
            if (cnt == 0) begin
               bus.i_bf_done = 1'b1;
               pend = 1'b0;
            end
         end else if (bus.o_bf_start === 1'b1) begin
            a_re = bus.o_bf_in0_re; a_im = bus.o_bf_in0_im;
            b_re = bus.o_bf_in1_re; b_im = bus.o_bf_in1_im;
            w_re = bus.o_bf_twiddle_re; w_im = bus.o_bf_twiddle_im;
            if (bf_mode) begin
               pr = (int'(w_re) * int'(b_re) - int'(w_im) * int'(b_im)) >>> 8;
               pi = (int'(w_re) * int'(b_im) + int'(w_im) * int'(b_re)) >>> 8;
               bus.i_bf_out0_re = 16'(int'(a_re) + pr);
               bus.i_bf_out0_im = 16'(int'(a_im) + pi);
               bus.i_bf_out1_re = 16'(int'(a_re) - pr);
               bus.i_bf_out1_im = 16'(int'(a_im) - pi);
            end else begin
               bus.i_bf_out0_re = a_re; bus.i_bf_out0_im = a_im;
               bus.i_bf_out1_re = b_re; bus.i_bf_out1_im = b_im;
            end
            if (chk_issue) begin
               s  = issue_cnt / 8;
               b  = issue_cnt % 8;
               p  = b % (1 << s);
               g  = b / (1 << s);
               i0 = g * (1 << (s + 1)) + p;
               i1 = i0 + (1 << s);
               k  = p * (1 << (3 - s));
               obs  = {a_re, b_re, w_re, w_im, 14'd0, bus.o_stage};
               expv = {16'(brev(i0)), 16'(brev(i1)), 16'(tw_re_t[k]), 16'(tw_im_t[k]), 14'd0, 2'(s)};
               checks++;
               if (obs !== expv || a_im !== 0 || b_im !== 0) begin
                  errors++;
                  $display("FAIL issue_%0d (s=%0d b=%0d): got in0=%0d in1=%0d tw=(%0d,%0d) stage=%0d, required in0=%0d in1=%0d tw=(%0d,%0d) stage=%0d",
                           issue_cnt, s, b, a_re, b_re, w_re, w_im, bus.o_stage, brev(i0), brev(i1), tw_re_t[k], tw_im_t[k], s);
               end
               if (issue_cnt > 0) begin
                  checks++;
                  if (cyc - last_start_cyc !== bf_latency + 2) begin
                     errors++;
                     $display("FAIL start_spacing_%0d: got %0d cycles, required %0d", issue_cnt, cyc - last_start_cyc, bf_latency + 2);
                  end
               end
               issue_cnt++;
            end
            last_start_cyc = cyc;
            cnt = bf_latency;
            pend = 1'b1;
         end
      end
   end

   task automatic apply_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic load_frame(input int gap_at, input int gap_len, input bit start_in_load);
      bus.i_start = 1'b1;
      @(posedge clk); #1;
      bus.i_start = 1'b0;
      checks++;
      if (bus.o_busy !== 1'b1 || bus.o_in_ready !== 1'b1) begin
         errors++;
         $display("FAIL busy_after_start: got busy=%b in_ready=%b, required 1 1", bus.o_busy, bus.o_in_ready);
      end
      for (int n = 0; n < 16; n++) begin
         if (n == gap_at) begin
            bus.i_in_valid = 1'b0;
            repeat (gap_len) begin
               @(posedge clk); #1;
               checks++;
               if (bus.o_in_ready !== 1'b1 || bus.o_bf_start !== 1'b0) begin
                  errors++;
                  $display("FAIL load_gap: got in_ready=%b bf_start=%b, required 1 0", bus.o_in_ready, bus.o_bf_start);
               end
            end
         end
         bus.i_in_valid = 1'b1;
         bus.i_in_re = x_re[n];
         bus.i_in_im = x_im[n];
         bus.i_start = start_in_load && (n == 5);
         @(posedge clk); #1;
      end
      bus.i_in_valid = 1'b0;
      bus.i_start = 1'b0;
   endtask

   task automatic push_passthrough();
      bin_t e;
      for (int i = 0; i < 16; i++) begin
         e.re = x_re[brev(i)];
         e.im = x_im[brev(i)];
         e.idx = 4'(i);
         exp_q.push_back(e);
      end
   endtask

   task automatic random_frame();
      for (int n = 0; n < 16; n++) begin
         x_re[n] = 16'($urandom);
         x_im[n] = 16'($urandom);
      end
   endtask

   task automatic collect_frame(input int stall_bin, input int stall_len);
      int got, waited, dr, di;
      bin_t e;
      logic [W-1:0] hre, him;
      got = 0;
      waited = 0;
      first_valid_cyc = -1;
      bus.i_out_ready = 1'b1;
      while (got < 16 && waited < 2000) begin
         if (bus.o_out_valid === 1'b1) begin
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            if (int'(bus.o_out_index) == stall_bin && stall_len > 0) begin
               hre = bus.o_out_re;
               him = bus.o_out_im;
               bus.i_out_ready = 1'b0;
               repeat (stall_len) begin
                  @(posedge clk); #1;
                  checks++;
                  if (bus.o_out_valid !== 1'b1 || int'(bus.o_out_index) != stall_bin ||
                      bus.o_out_re !== hre || bus.o_out_im !== him) begin
                     errors++;
                     $display("FAIL stall_hold: got valid=%b idx=%0d (%0d,%0d), required 1 %0d (%0d,%0d)",
                              bus.o_out_valid, bus.o_out_index, bus.o_out_re, bus.o_out_im, stall_bin, hre, him);
                  end
               end
               stall_len = 0;
               bus.i_out_ready = 1'b1;
            end
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_bin: got idx=%0d with empty scoreboard, required none", bus.o_out_index);
            end else begin
               e = exp_q.pop_front();
               dr = int'($signed(bus.o_out_re)) - int'(e.re);
               di = int'($signed(bus.o_out_im)) - int'(e.im);
               if (dr < 0) dr = -dr;
               if (di < 0) di = -di;
               if (bus.o_out_index !== e.idx || dr > tol || di > tol) begin
                  errors++;
                  $display("FAIL bin_%0d: got idx=%0d (%0d,%0d), required idx=%0d (%0d,%0d) tol %0d",
                           got, bus.o_out_index, $signed(bus.o_out_re), $signed(bus.o_out_im), e.idx, e.re, e.im, tol);
               end
            end
            got++;
         end
         @(posedge clk); #1;
         waited++;
      end
      checks++;
      if (got < 16) begin
         errors++;
         $display("FAIL unload_timeout: got %0d bins, required 16", got);
      end else if (bus.o_frame_done !== 1'b1 || bus.o_busy !== 1'b0 || bus.o_out_valid !== 1'b0) begin
         errors++;
         $display("FAIL frame_done: got done=%b busy=%b valid=%b, required 1 0 0", bus.o_frame_done, bus.o_busy, bus.o_out_valid);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.o_frame_done !== 1'b0) begin
         errors++;
         $display("FAIL frame_done_pulse: got done=%b one cycle later, required 0", bus.o_frame_done);
      end
   endtask

   task automatic wait_stage_start(input int stage);
      int t;
      t = 0;
      while (!(bus.o_bf_start === 1'b1 && int'(bus.o_stage) == stage) && t < 1000) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 1000) begin
         checks++;
         errors++;
         $display("FAIL wait_stage_%0d: got no start pulse, required one", stage);
      end
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if ({bus.o_in_ready, bus.o_out_valid, bus.o_bf_start, bus.o_busy, bus.o_frame_done, bus.o_stage, bus.o_out_index} !== 11'd0) begin
         errors++;
         $display("FAIL reset_ctrl: got rdy=%b vld=%b start=%b busy=%b done=%b stage=%0d idx=%0d, required all 0",
                  bus.o_in_ready, bus.o_out_valid, bus.o_bf_start, bus.o_busy, bus.o_frame_done, bus.o_stage, bus.o_out_index);
      end
      checks++;
      if ({bus.o_out_re, bus.o_out_im, bus.o_bf_in0_re, bus.o_bf_in0_im, bus.o_bf_in1_re, bus.o_bf_in1_im,
           bus.o_bf_twiddle_re, bus.o_bf_twiddle_im} !== 128'd0) begin
         errors++;
         $display("FAIL reset_data: got out=(%0d,%0d) tw=(%0d,%0d), required all 0",
                  bus.o_out_re, bus.o_out_im, bus.o_bf_twiddle_re, bus.o_bf_twiddle_im);
      end
      rst_n = 1'b1;
      spurious_done = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         checks++;
         if (bus.o_busy !== 1'b0 || bus.o_in_ready !== 1'b0 || bus.o_bf_start !== 1'b0) begin
            errors++;
            $display("FAIL idle_spurious_done: got busy=%b rdy=%b start=%b, required 0 0 0", bus.o_busy, bus.o_in_ready, bus.o_bf_start);
         end
      end
      spurious_done = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_addressing();
      bf_mode = 1'b0;
      bf_latency = 3;
      tol = 0;
      for (int n = 0; n < 16; n++) begin
         x_re[n] = 16'(n);
         x_im[n] = '0;
      end
      push_passthrough();
      issue_cnt = 0;
      chk_issue = 1'b1;
      load_frame(-1, 0, 1'b0);
      collect_frame(-1, 0);
      chk_issue = 1'b0;
      checks++;
      if (issue_cnt !== 32) begin
         errors++;
         $display("FAIL start_count: got %0d, required 32", issue_cnt);
      end
      checks++;
      if (first_valid_cyc - last_start_cyc !== bf_latency + 2) begin
         errors++;
         $display("FAIL first_valid_latency: got %0d, required %0d", first_valid_cyc - last_start_cyc, bf_latency + 2);
      end
   endtask

   task automatic test_impulse();
      bin_t e;
      bf_mode = 1'b1;
      bf_latency = 2;
      tol = 1;
      for (int n = 0; n < 16; n++) begin
         x_re[n] = (n == 0) ? 16'sd256 : 16'sd0;
         x_im[n] = '0;
      end
      for (int i = 0; i < 16; i++) begin
         e.re = 16'sd256; e.im = 16'sd0; e.idx = 4'(i);
         exp_q.push_back(e);
      end
      load_frame(-1, 0, 1'b0);
      collect_frame(-1, 0);
   endtask

   task automatic test_dc();
      bin_t e;
      bf_mode = 1'b1;
      bf_latency = 1;
      tol = 2;
      for (int n = 0; n < 16; n++) begin
         x_re[n] = 16'sd256;
         x_im[n] = '0;
      end
      for (int i = 0; i < 16; i++) begin
         e.re = (i == 0) ? 16'sd4096 : 16'sd0; e.im = 16'sd0; e.idx = 4'(i);
         exp_q.push_back(e);
      end
      load_frame(-1, 0, 1'b0);
      collect_frame(-1, 0);
   endtask

   task automatic test_backpressure();
      bf_mode = 1'b0;
      bf_latency = 3;
      tol = 0;
      random_frame();
      push_passthrough();
      load_frame(6, 4, 1'b0);
      collect_frame(7, 5);
   endtask

   task automatic test_ignored_start();
      bf_mode = 1'b0;
      bf_latency = 4;
      tol = 0;
      random_frame();
      push_passthrough();
      load_frame(-1, 0, 1'b1);
      wait_stage_start(1);
      @(posedge clk); #1;
      bus.i_start = 1'b1;
      @(posedge clk); #1;
      bus.i_start = 1'b0;
      checks++;
      if (bus.o_busy !== 1'b1 || bus.o_in_ready !== 1'b0) begin
         errors++;
         $display("FAIL start_in_wait: got busy=%b rdy=%b, required 1 0", bus.o_busy, bus.o_in_ready);
      end
      collect_frame(-1, 0);
   endtask

   task automatic test_reset_mid_compute();
      bit bad;
      bf_mode = 1'b0;
      bf_latency = 3;
      tol = 0;
      random_frame();
      load_frame(-1, 0, 1'b0);
      wait_stage_start(2);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (bus.o_busy !== 1'b0 || bus.o_bf_start !== 1'b0 || bus.o_out_valid !== 1'b0 || bus.o_stage !== 2'd0) begin
         errors++;
         $display("FAIL reset_mid: got busy=%b start=%b valid=%b stage=%0d, required 0 0 0 0",
                  bus.o_busy, bus.o_bf_start, bus.o_out_valid, bus.o_stage);
      end
      rst_n = 1'b1;
      bad = 1'b0;
      repeat (20) begin
         @(posedge clk); #1;
         if (bus.o_bf_start !== 1'b0 || bus.o_out_valid !== 1'b0 || bus.o_busy !== 1'b0) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL after_reset_quiet: got activity after abort, required none");
      end
      random_frame();
      push_passthrough();
      load_frame(-1, 0, 1'b0);
      collect_frame(-1, 0);
   endtask

   initial begin
      rst_n = 1'b0;
      bus.i_start = 1'b0;
      bus.i_in_valid = 1'b0;
      bus.i_in_re = '0;
      bus.i_in_im = '0;
      bus.i_out_ready = 1'b0;
      test_reset();
      test_addressing();
      test_impulse();
      test_dc();
      test_backpressure();
      test_ignored_start();
      test_reset_mid_compute();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_leftover: got %0d pending bins, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/fft16_scheduler.md
# fft16_scheduler

Sequencer for the 16-point radix-2 decimation-in-time FFT built around the shared `butterfly2` datapath. It buffers one 16-sample complex frame in an internal in-place memory, stored in bit-reversed order. It then issues all 32 butterfly operations (4 stages × 8) to the external butterfly with the correct operand pairs and Q8.8 twiddles, writes the results back, and streams the spectrum out in natural order.

## Interface
- WORD_SIZE, 16, width of each real/imag component (two's complement)
- FRACTION, 8, fractional bits of the twiddle format (twiddle ROM is defined for 8)

Ports:
- i_clk  in  1  system clock, all logic on rising edge
- i_rst  in  1  synchronous, active-low reset
- i_start  in  1  begin a frame when idle
- i_in_valid  in  1  input sample valid
- o_in_ready  out  1  input sample accepted when high together with i_in_valid
- i_in_re, i_in_im  in  WORD_SIZE  input sample
- o_out_valid  out  1  output bin valid
- i_out_ready  in  1  consumer accepts bin
- o_out_re, o_out_im  out  WORD_SIZE  output bin
- o_out_index  out  4  bin number 0..15
- o_bf_start  out  1  one-cycle butterfly launch pulse
- o_bf_in0_re, o_bf_in0_im, o_bf_in1_re, o_bf_in1_im  out  WORD_SIZE  butterfly operands
- o_bf_twiddle_re, o_bf_twiddle_im  out  WORD_SIZE  twiddle W16^k
- i_bf_done  in  1  butterfly result valid
- i_bf_out0_re, i_bf_out0_im, i_bf_out1_re, i_bf_out1_im  in  WORD_SIZE  butterfly results
- o_busy  out  1  high from accepted start until last bin accepted
- o_stage  out  2  current compute stage
- o_frame_done  out  1  one-cycle pulse after bin 15 is accepted

## Operation
- States: IDLE → LOAD → ISSUE → WAIT → WRITE → (ISSUE | UNLOAD) → IDLE.
- IDLE:
  - i_start moves the block to LOAD and clears the load count.
  - i_start is ignored in all other states.
- LOAD:
  - o_in_ready=1.
  - Accepted sample n (0..15) is written to mem[bitrev4(n)].
  - After the 16th accept, go to ISSUE with stage s=0 and butterfly b=0.
- Operand addressing for stage s and butterfly b:
  - p = b & (2^s−1), g = b >> s.
  - idx0 = g·2^(s+1) + p; idx1 = idx0 + 2^s.
  - Twiddle k = p << (3−s).
- Twiddle ROM (re, im) for k=0..7: (256,0), (237,−98), (181,−181), (98,−237), (0,−256), (−98,−237), (−181,−181), (−237,−98).
- ISSUE:
  - Drive operands mem[idx0], mem[idx1] and twiddle k.
  - Pulse o_bf_start for one cycle, then go to WAIT.
- WAIT:
  - Operand and twiddle outputs are held stable.
  - Stay until i_bf_done=1.
  - Results are captured in the cycle i_bf_done is high.
- WRITE:
  - Write out0 → mem[idx0] and out1 → mem[idx1] (in place).
  - Increment b. On wrap of b (7→0), increment s.
  - After s=3, b=7, go to UNLOAD; otherwise go to ISSUE.
- UNLOAD:
  - Present mem[i] with o_out_index=i, i=0..15, with valid/ready.
  - Data is held while i_out_ready=0.
  - The accept of i=15 pulses o_frame_done and returns to IDLE.
- No arithmetic is done here. Scaling and overflow belong to the butterfly, and results are stored unmodified.
- i_bf_done outside WAIT is ignored.

## Timing
- Reset (i_rst=0 at a clock edge):
  - Go to IDLE. Counters s, b, n, i are cleared.
  - Output values after reset: o_in_ready=0, o_out_valid=0, o_bf_start=0, o_busy=0, o_frame_done=0, o_stage=0, o_out_index=0.
  - All data outputs are 0.
  - Memory contents are not reset and not guaranteed.
- Reset mid-operation aborts the frame immediately. No further o_bf_start or o_out_valid is issued.
- o_busy rises the cycle after the accepted i_start.
- LOAD takes ≥16 cycles, one per accepted beat.
- Each butterfly takes N+2 cycles, where N = cycles from o_bf_start to i_bf_done (N≥1).
- Compute total: 32·(N+2) cycles.
- The first o_out_valid appears the cycle after the final WRITE.
- UNLOAD takes 16 cycles at full throughput (one bin per cycle with i_out_ready=1).
- o_busy falls in the same cycle o_frame_done pulses.
- i_bf_done arriving the cycle after o_bf_start (N=1) is legal.

## Test plan
- Impulse: x[0]=(256,0), others 0, with a reference butterfly (out0=in0+W·in1, out1=in0−W·in1, Q8.8) → all 16 bins =(256,0) ±1 LSB; o_frame_done pulses once.
- DC: all x[n]=(256,0) → bin 0 =(4096,0), bins 1..15 =(0,0) ±2 LSB.
- Addressing (pass-through stub butterfly, out0=in0, out1=in1, N=3):
  - Load x[n]=(n,0) → bin i =(bitrev4(i),0); e.g. bin 1 =(8,0).
  - Check 32 start pulses, each 5 cycles apart.
  - Stage 1, butterfly 1 issues mem[1], mem[3] with twiddle (0,−256).
- Backpressure: hold i_out_ready=0 for 5 cycles at bin 7 → o_out_re/im/index stable and bin 8 not presented early. Likewise hold i_in_valid low mid-load → load count frozen.
- Reset mid-compute: assert i_rst=0 during stage 2 WAIT → next cycle o_busy=0 and o_bf_start=0; a subsequent full frame is correct.
- i_start during LOAD and WAIT, and spurious i_bf_done in IDLE → no state change, results unaffected.
